ias_mem_responder: RTL and testbench

Memory-side responder for the IAS core's memory bus. It owns a 16x8 storage array and serves word reads and writes over a req/ack handshake. It has two requester ports: the CPU port, driven by the IAS control unit, and a host port used for program loading and debug readback. The block adds a configurable access latency and fair arbitration between the two ports, so the control unit must wait on an acknowledge rather than assume a fixed one-cycle memory.

---
 rtl/ias_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_ias_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ias_mem_responder.sv
// ias_mem_responder
//   Memory-side responder for the IAS memory bus. Holds a 2**ADDR_W x DATA_W
//   storage array and serves single-word reads/writes from two requester
//   ports (CPU and host) over a req/ack handshake. Each access takes
//   WAIT_CYCLES extra cycles before its one-cycle ack. When both ports request
//   in the same cycle, the port that did not win the previous contended
//   arbitration is granted.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request; held until cpu_ack
//   cpu_ack, cpu_rdata      CPU completion pulse, read data (held until next CPU read)
//   host_req/we/addr/wdata  host request (program load / debug readback)
//   host_ack, host_rdata    host completion pulse, read data
//   busy                    high while a transaction is in flight
module ias_mem_responder #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              last_host;
  logic              sel_host;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              grant;
  logic              grant_host;
  logic              commit;
  logic              c_host;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;

  // The commit operands come straight from the granted port when the access
  // commits on its grant edge (WAIT_CYCLES = 0); otherwise from the capture.
  always_comb begin
    grant      = cpu_req | host_req;
    grant_host = host_req & (~cpu_req | ~last_host);
    commit     = 1'b0;
    c_host     = sel_host;
    c_we       = we_q;
    c_addr     = addr_q;
    c_wdata    = wdata_q;
    if (state == ST_IDLE) begin
      commit  = grant && (WAIT_CYCLES == 0);
      c_host  = grant_host;
      c_we    = grant_host ? host_we    : cpu_we;
      c_addr  = grant_host ? host_addr  : cpu_addr;
      c_wdata = grant_host ? host_wdata : cpu_wdata;
    end else if (state == ST_WAIT) begin
      commit = (cnt == '0);
    end
  end

  // Storage is never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_we) begin
      mem[c_addr] <= c_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_host  <= 1'b0;
      sel_host   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      busy       <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            sel_host <= c_host;
            we_q     <= c_we;
            addr_q   <= c_addr;
            wdata_q  <= c_wdata;
            busy     <= 1'b1;
            // Fairness memory only moves when the two ports actually contend.
            if (cpu_req && host_req) begin
              last_host <= grant_host;
            end
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (commit) begin
        if (c_host) begin
          host_ack <= 1'b1;
        end else begin
          cpu_ack <= 1'b1;
        end
        if (!c_we) begin
          if (c_host) begin
            host_rdata <= mem[c_addr];
          end else begin
            cpu_rdata <= mem[c_addr];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ias_mem_responder.sv
// Bench for ias_mem_responder: instance 0 uses WAIT_CYCLES=2, instance 1
// uses WAIT_CYCLES=0. Inputs change and outputs are sampled on the falling
// edge. The reference model works per transaction: it predicts the ack
// cycles from the latency rule and the arbitration order, and keeps the
// memory image and each port's read-data value.
module tb_ias_mem_responder;

  logic       clk = 1'b0;
  logic       reset      [2];
  logic       cpu_req    [2];
  logic       cpu_we     [2];
  logic [3:0] cpu_addr   [2];
  logic [7:0] cpu_wdata  [2];
  logic       cpu_ack    [2];
  logic [7:0] cpu_rdata  [2];
  logic       host_req   [2];
  logic       host_we    [2];
  logic [3:0] host_addr  [2];
  logic [7:0] host_wdata [2];
  logic       host_ack   [2];
  logic [7:0] host_rdata [2];
  logic       busy       [2];

  always #5 clk = ~clk;

  ias_mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset[0]),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]),
    .cpu_wdata(cpu_wdata[0]), .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .host_req(host_req[0]), .host_we(host_we[0]), .host_addr(host_addr[0]),
    .host_wdata(host_wdata[0]), .host_ack(host_ack[0]), .host_rdata(host_rdata[0]),
    .busy(busy[0])
  );

  ias_mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset[1]),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]),
    .cpu_wdata(cpu_wdata[1]), .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .host_req(host_req[1]), .host_we(host_we[1]), .host_addr(host_addr[1]),
    .host_wdata(host_wdata[1]), .host_ack(host_ack[1]), .host_rdata(host_rdata[1]),
    .busy(busy[1])
  );

  // Reference model state
  logic [7:0] mdl [2][16];
  logic [7:0] mrd [2][2];   // [instance][0=cpu,1=host]
  bit         mlast_host [2];
  int         checks = 0;
  int         passes = 0;

  function automatic int wcyc(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_port(input int i, input int p, input logic rq, input logic we,
                          input logic [3:0] a, input logic [7:0] d);
    if (p == 0) begin
      cpu_req[i] = rq; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d;
    end else begin
      host_req[i] = rq; host_we[i] = we; host_addr[i] = a; host_wdata[i] = d;
    end
  endtask

  task automatic set_req(input int i, input int p, input logic rq);
    if (p == 0) cpu_req[i] = rq;
    else host_req[i] = rq;
  endtask

  task automatic scramble(input int i, input int p);
    if (p == 0) begin
      cpu_addr[i] = 4'($urandom); cpu_wdata[i] = 8'($urandom);
    end else begin
      host_addr[i] = 4'($urandom); host_wdata[i] = 8'($urandom);
    end
  endtask

  task automatic check_outputs(input int i, input logic eca, input logic eha,
                               input logic eb, input string tag);
    chk({tag, " cpu_ack"},    cpu_ack[i],    eca);
    chk({tag, " host_ack"},   host_ack[i],   eha);
    chk({tag, " busy"},       busy[i],       eb);
    chk({tag, " cpu_rdata"},  cpu_rdata[i],  mrd[i][0]);
    chk({tag, " host_rdata"}, host_rdata[i], mrd[i][1]);
  endtask

  task automatic model_reset(input int i);
    mlast_host[i] = 1'b0;
    mrd[i][0] = 8'h00;
    mrd[i][1] = 8'h00;
  endtask

  // Called just after a falling edge.
  task automatic do_reset(input int i);
    reset[i] = 1'b1;
    set_port(i, 0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_port(i, 1, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    model_reset(i);
    check_outputs(i, 1'b0, 1'b0, 1'b0, "reset");
    reset[i] = 1'b0;
  endtask

  // One or two simultaneous requests, run to completion. Starts and ends
  // just after a falling edge with the DUT idle.
  task automatic run_pair(input int i, input string tag,
                          input bit c_en, input bit c_we, input logic [3:0] c_a, input logic [7:0] c_d,
                          input bit h_en, input bit h_we, input logic [3:0] h_a, input logic [7:0] h_d);
    int w;
    int first;
    int second;
    int end_t;
    int grc [2];
    int ackc [2];
    bit en [2];
    bit we [2];
    logic [3:0] a [2];
    logic [7:0] d [2];
    logic eb;
    w = wcyc(i);
    en[0] = c_en; we[0] = c_we; a[0] = c_a; d[0] = c_d;
    en[1] = h_en; we[1] = h_we; a[1] = h_a; d[1] = h_d;
    grc[0] = -1; grc[1] = -1; ackc[0] = -1; ackc[1] = -1;
    if (en[0] && en[1]) begin
      first = mlast_host[i] ? 0 : 1;
      mlast_host[i] = (first == 1);
    end else begin
      first = en[0] ? 0 : 1;
    end
    second = 1 - first;
    grc[first] = 0;
    ackc[first] = w + 1;
    end_t = w + 2;
    if (en[second]) begin
      grc[second] = w + 2;
      ackc[second] = 2 * w + 3;
      end_t = 2 * w + 4;
    end
    for (int p = 0; p < 2; p++) set_port(i, p, en[p], we[p], a[p], d[p]);
    for (int t = 1; t <= end_t; t++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (en[p] && t == ackc[p]) begin
          if (we[p]) mdl[i][a[p]] = d[p];
          else mrd[i][p] = mdl[i][a[p]];
        end
      end
      eb = (en[0] && t > grc[0] && t <= ackc[0]) || (en[1] && t > grc[1] && t <= ackc[1]);
      check_outputs(i, logic'(t == ackc[0]), logic'(t == ackc[1]), eb, tag);
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          if (t == ackc[p]) set_req(i, p, 1'b0);
          else if (t > grc[p] && t < ackc[p]) scramble(i, p);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1;
      set_port(i, 0, 1'b0, 1'b0, 4'h0, 8'h00);
      set_port(i, 1, 1'b0, 1'b0, 4'h0, 8'h00);
      for (int k = 0; k < 16; k++) mdl[i][k] = 8'h00;
      model_reset(i);
    end
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // 1: host write addr 0 = 15
    run_pair(0, "t1", 0, 0, 4'h0, 8'h00, 1, 1, 4'h0, 8'h15);
    // 2: CPU read addr 0
    run_pair(0, "t2", 1, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
    chk("t2 cpu_rdata 15", cpu_rdata[0], 8'h15);

    // 3: ties after reset - host first, then CPU first
    do_reset(0);
    run_pair(0, "t3a", 1, 0, 4'h3, 8'h00, 1, 1, 4'h3, 8'hA5);
    chk("t3a cpu_rdata A5", cpu_rdata[0], 8'hA5);
    run_pair(0, "t3b", 1, 1, 4'h4, 8'h3C, 1, 0, 4'h3, 8'h00);
    chk("t3b host_rdata A5", host_rdata[0], 8'hA5);

    // 4: reset on the commit edge of a host write
    run_pair(0, "t4pre", 0, 0, 4'h0, 8'h00, 1, 1, 4'h5, 8'h00);
    set_port(0, 1, 1'b1, 1'b1, 4'h5, 8'h77);
    @(negedge clk);
    check_outputs(0, 1'b0, 1'b0, 1'b1, "t4 c1");
    @(negedge clk);
    check_outputs(0, 1'b0, 1'b0, 1'b1, "t4 c2");
    reset[0] = 1'b1;
    @(negedge clk);
    model_reset(0);
    check_outputs(0, 1'b0, 1'b0, 1'b0, "t4 c3");
    reset[0] = 1'b0;
    set_req(0, 1, 1'b0);
    @(negedge clk);
    check_outputs(0, 1'b0, 1'b0, 1'b0, "t4 c4");
    run_pair(0, "t4rd", 0, 0, 4'h0, 8'h00, 1, 0, 4'h5, 8'h00);
    chk("t4 readback 00", host_rdata[0], 8'h00);

    // 5: WAIT_CYCLES=0, CPU back-to-back reads with req held
    run_pair(1, "t5pre0", 0, 0, 4'h0, 8'h00, 1, 1, 4'h0, 8'h15);
    run_pair(1, "t5pre3", 0, 0, 4'h0, 8'h00, 1, 1, 4'h3, 8'hA5);
    set_port(1, 0, 1'b1, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    mrd[1][0] = mdl[1][0];
    check_outputs(1, 1'b1, 1'b0, 1'b1, "t5 c1");
    chk("t5 rdata 15", cpu_rdata[1], 8'h15);
    cpu_addr[1] = 4'h3;
    @(negedge clk);
    check_outputs(1, 1'b0, 1'b0, 1'b0, "t5 c2");
    @(negedge clk);
    mrd[1][0] = mdl[1][3];
    check_outputs(1, 1'b1, 1'b0, 1'b1, "t5 c3");
    chk("t5 rdata A5", cpu_rdata[1], 8'hA5);
    set_req(1, 0, 1'b0);
    @(negedge clk);
    check_outputs(1, 1'b0, 1'b0, 1'b0, "t5 c4");

    // 6: fill memory, CPU write 7 = 42 with inputs scrambled during WAIT,
    //    then read every address back
    for (int k = 0; k < 16; k++)
      run_pair(0, "fill0", 0, 0, 4'h0, 8'h00, 1, 1, 4'(k), 8'($urandom));
    run_pair(0, "t6wr", 1, 1, 4'h7, 8'h42, 0, 0, 4'h0, 8'h00);
    for (int k = 0; k < 16; k++) begin
      run_pair(0, "t6rd", 0, 0, 4'h0, 8'h00, 1, 0, 4'(k), 8'h00);
      if (k == 7) chk("t6 mem7 42", host_rdata[0], 8'h42);
    end

    // Randomized traffic on both instances
    for (int k = 0; k < 16; k++)
      run_pair(1, "fill1", 0, 0, 4'h0, 8'h00, 1, 1, 4'(k), 8'($urandom));
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 40; n++) begin
        bit ce;
        bit he;
        ce = 1'($urandom);
        he = 1'($urandom);
        if (!ce && !he) ce = 1'b1;
        run_pair(i, "rand", ce, 1'($urandom), 4'($urandom), 8'($urandom),
                 he, 1'($urandom), 4'($urandom), 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
